sample_tick_player: RTL and testbench

Consumer side of the audio sample clock. Buffers samples pushed by the CPU/synth side in a small FIFO. Detects each rising edge of `sample_clock`, pops exactly one sample per edge and presents it to the DAC/mixer path with a one-cycle strobe. Flags and counts underruns when a tick finds the FIFO empty.

---
 rtl/sample_tick_player_pkg.sv | 15 +
 rtl/sample_tick_player_fifo.sv | 65 ++++++
 rtl/sample_tick_player.sv | 91 +++++++++
 tb/tb_sample_tick_player.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_tick_player_pkg.sv
// Shared audio definitions: sample width and underrun counter helpers.
package sample_tick_player_pkg;

    localparam int AUDIO_SAMPLE_WIDTH   = 16;
    localparam int UNDERRUN_COUNT_WIDTH = 8;

    localparam logic [UNDERRUN_COUNT_WIDTH-1:0] UNDERRUN_COUNT_MAX = '1;

    function automatic logic [UNDERRUN_COUNT_WIDTH-1:0] sat_inc(
        input logic [UNDERRUN_COUNT_WIDTH-1:0] value
    );
        return (value == UNDERRUN_COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sample_tick_player_fifo.sv
// Single-clock sample FIFO; level carries full/empty, pointers wrap modulo depth.
module audio_sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        push_ok  = push & (level_q != LEVEL_FULL);
        pop_ok   = pop & (level_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an empty level makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/sample_tick_player.sv
// Pops one buffered sample per sample_clock rise toward the DAC; tracks underruns.
module sample_tick_player
    import sample_tick_player_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_clock,
    input  logic [SAMPLE_WIDTH-1:0]           in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [SAMPLE_WIDTH-1:0]           sample_out,
    output logic                              sample_strobe,
    output logic [DEPTH_LOG2:0]               level,
    output logic                              underrun,
    input  logic                              underrun_clr,
    output logic [UNDERRUN_COUNT_WIDTH-1:0]   underrun_count
);

    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic                            sample_clock_d_q;
    logic                            tick;
    logic                            push, pop, underrun_tick;
    logic [SAMPLE_WIDTH-1:0]         fifo_rdata;
    logic [DEPTH_LOG2:0]             fifo_level;
    logic [SAMPLE_WIDTH-1:0]         sample_out_q, sample_out_d;
    logic                            sample_strobe_q, sample_strobe_d;
    logic                            underrun_q, underrun_d;
    logic [UNDERRUN_COUNT_WIDTH-1:0] underrun_count_q, underrun_count_d;

    audio_sync_fifo #(
        .WIDTH      (SAMPLE_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .level (fifo_level)
    );

    // No bypass: a push landing with an empty-FIFO tick is stored, and the tick underruns.
    always_comb begin
        in_ready         = (fifo_level != LEVEL_FULL);
        tick             = sample_clock & ~sample_clock_d_q;
        push             = in_valid & in_ready;
        pop              = tick & (fifo_level != '0);
        underrun_tick    = tick & (fifo_level == '0);
        sample_out_d     = pop ? fifo_rdata : sample_out_q;
        sample_strobe_d  = pop;
        underrun_d       = underrun_q;
        underrun_count_d = underrun_count_q;
        if (underrun_tick) begin
            underrun_d       = 1'b1;
            underrun_count_d = underrun_clr ? UNDERRUN_COUNT_WIDTH'(1)
                                            : sat_inc(underrun_count_q);
        end else if (underrun_clr) begin
            underrun_d       = 1'b0;
            underrun_count_d = '0;
        end
    end

    // Edge history resets high so a sample_clock already high at release is not a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_clock_d_q <= 1'b1;
            sample_out_q     <= '0;
            sample_strobe_q  <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            sample_clock_d_q <= sample_clock;
            sample_out_q     <= sample_out_d;
            sample_strobe_q  <= sample_strobe_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign sample_out     = sample_out_q;
    assign sample_strobe  = sample_strobe_q;
    assign level          = fifo_level;
    assign underrun       = underrun_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_sample_tick_player.sv
// Directed self-checking bench for sample_tick_player.
module tb_sample_tick_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clock;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sample_out;
    logic        sample_strobe;
    logic [4:0]  level;
    logic        underrun;
    logic        underrun_clr;
    logic [7:0]  underrun_count;

    int checks = 0;
    int errors = 0;

    sample_tick_player #(
        .SAMPLE_WIDTH (16),
        .DEPTH_LOG2   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_clock   (sample_clock),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sample_out     (sample_out),
        .sample_strobe  (sample_strobe),
        .level          (level),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Low for one cycle then high; returns 1 time unit after the edge that pops.
    task automatic tick();
        @(negedge clk) sample_clock = 1'b0;
        @(negedge clk) sample_clock = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk) begin
            in_valid = 1'b1;
            in_data  = d;
        end
        @(negedge clk) in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_clock = 1'b1; in_data = '0; in_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_strobe", 32'(sample_strobe), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_count", 32'(underrun_count), 32'd0);

        // Release with sample_clock high: no tick.
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_no_strobe", 32'(sample_strobe), 32'd0);
        chk("rel_no_underrun", 32'(underrun), 32'd0);
        tick();
        chk("first_tick_underrun", 32'(underrun), 32'd1);
        chk("first_tick_count", 32'(underrun_count), 32'd1);
        chk("first_tick_no_strobe", 32'(sample_strobe), 32'd0);
        @(negedge clk) underrun_clr = 1'b1;
        @(posedge clk) #1;
        underrun_clr = 1'b0;
        chk("clr1_underrun", 32'(underrun), 32'd0);
        chk("clr1_count", 32'(underrun_count), 32'd0);

        // Three samples, three ticks.
        push(16'h1111); push(16'h2222); push(16'h3333);
        chk("three_level", 32'(level), 32'd3);
        tick();
        chk("pop1_out", 32'(sample_out), 32'h1111);
        chk("pop1_strobe", 32'(sample_strobe), 32'd1);
        chk("pop1_level", 32'(level), 32'd2);
        @(posedge clk) #1;
        chk("pop1_strobe_one_cycle", 32'(sample_strobe), 32'd0);
        tick();
        chk("pop2_out", 32'(sample_out), 32'h2222);
        chk("pop2_strobe", 32'(sample_strobe), 32'd1);
        tick();
        chk("pop3_out", 32'(sample_out), 32'h3333);
        chk("pop3_level", 32'(level), 32'd0);
        chk("pop3_no_underrun", 32'(underrun), 32'd0);
        @(posedge clk) #1;
        chk("held_high_no_tick", 32'(sample_strobe), 32'd0);

        // Fill with in_valid held through a 17th attempt.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk) begin
                in_valid = 1'b1;
                in_data  = 16'h0100 + 16'(i);
            end
        end
        @(negedge clk) in_valid = 1'b0;
        chk("full_level", 32'(level), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("pop_full_out", 32'(sample_out), 32'h0100);
        chk("pop_full_level", 32'(level), 32'd15);
        chk("pop_full_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("drain_last_out", 32'(sample_out), 32'h010F);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_no_underrun", 32'(underrun), 32'd0);

        // 300 underrun ticks saturate the counter.
        for (int i = 0; i < 300; i++) tick();
        chk("sat_hold_out", 32'(sample_out), 32'h010F);
        chk("sat_underrun", 32'(underrun), 32'd1);
        chk("sat_count", 32'(underrun_count), 32'd255);
        chk("sat_no_strobe", 32'(sample_strobe), 32'd0);
        @(negedge clk) underrun_clr = 1'b1;
        @(posedge clk) #1;
        underrun_clr = 1'b0;
        chk("clr2_underrun", 32'(underrun), 32'd0);
        chk("clr2_count", 32'(underrun_count), 32'd0);

        // Clear coinciding with an underrun tick: set wins, count restarts at 1.
        tick(); tick();
        chk("pre_clr_count", 32'(underrun_count), 32'd2);
        @(negedge clk) sample_clock = 1'b0;
        @(negedge clk) begin
            sample_clock = 1'b1;
            underrun_clr = 1'b1;
        end
        @(posedge clk) #1;
        underrun_clr = 1'b0;
        chk("clr_tick_underrun", 32'(underrun), 32'd1);
        chk("clr_tick_count", 32'(underrun_count), 32'd1);

        // Push coinciding with an empty tick: no bypass.
        @(negedge clk) sample_clock = 1'b0;
        @(negedge clk) begin
            sample_clock = 1'b1;
            in_valid     = 1'b1;
            in_data      = 16'hABCD;
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        chk("nobypass_count", 32'(underrun_count), 32'd2);
        chk("nobypass_level", 32'(level), 32'd1);
        chk("nobypass_strobe", 32'(sample_strobe), 32'd0);
        chk("nobypass_out", 32'(sample_out), 32'h010F);
        tick();
        chk("after_bypass_out", 32'(sample_out), 32'hABCD);
        chk("after_bypass_strobe", 32'(sample_strobe), 32'd1);
        chk("after_bypass_level", 32'(level), 32'd0);

        // Async reset mid-stream with five samples queued.
        for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i));
        chk("mid_level", 32'(level), 32'd5);
        @(posedge clk) #3;
        rst = 1'b1;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_out", 32'(sample_out), 32'h0);
        chk("async_underrun", 32'(underrun), 32'd0);
        chk("async_count", 32'(underrun_count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        push(16'h0777);
        chk("post_rst_level", 32'(level), 32'd1);
        tick();
        chk("post_rst_out", 32'(sample_out), 32'h0777);
        chk("post_rst_strobe", 32'(sample_strobe), 32'd1);
        chk("post_rst_level0", 32'(level), 32'd0);
        chk("post_rst_no_underrun", 32'(underrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
